shift_pipe: RTL and testbench
=============================

SHIFT_PIPE -- requirements
Module: shift_pipe

Interface
REQ-001 Parameter: WIDTH, default 8, data width; SHALL be a power of two, 2..64.
REQ-002 Parameter: SHW, default $clog2(WIDTH), shift-amount width; derived, not overridden.
REQ-003 Port: clk  input  1  rising-edge clock, the only clock.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: in_valid  input  1  request present.
REQ-006 Port: in_ready  output  1  request accepted when in_valid && in_ready at the clk edge.
REQ-007 Port: in_data  input  WIDTH  operand.
REQ-008 Port: in_amt  input  SHW  shift amount, 0..WIDTH-1.
REQ-009 Port: in_op  input  3  operation code.
REQ-010 Port: out_valid  output  1  result present.
REQ-011 Port: out_ready  input  1  consumer takes result when out_valid && out_ready.
REQ-012 Port: out_data  output  WIDTH  result.
REQ-013 Port: out_err  output  1  set with a result whose op was illegal.

Function
REQ-014 Op codes SHALL be: 000 PASS, 001 SLL, 010 SRL, 011 SRA, 100 ROL, 101 ROR; 110 and 111 are illegal.
REQ-015 SLL/SRL SHALL zero-fill; SRA SHALL replicate in_data[WIDTH-1]; ROL/ROR SHALL wrap bits modulo WIDTH.
REQ-016 Datapath SHALL be SHW registered stages; stage k applies shift 2^k when amount bit k is 1, else passes data unchanged.
REQ-017 Each stage SHALL carry valid, data, op, remaining amount bits and err.
REQ-018 Latency SHALL be exactly SHW cycles from acceptance to out_valid with no backpressure.
REQ-019 Throughput SHALL be one result per cycle while out_ready stays high.
REQ-020 The pipeline SHALL advance only when !(out_valid && !out_ready); otherwise all stages hold, and in_ready SHALL be low.
REQ-021 in_ready SHALL be high whenever the pipeline advances, including when it is empty.
REQ-022 A stage holding no valid entry SHALL absorb a bubble; results SHALL leave in acceptance order, with no loss or duplication.
REQ-023 Amount 0 and op PASS SHALL return in_data unchanged after the same latency.
REQ-024 Illegal op SHALL produce out_data = 0 and out_err = 1, still with full latency.
REQ-025 out_data and out_err SHALL be held stable while out_valid && !out_ready.

Reset
REQ-026 On rst, all stage valids, out_valid and out_err SHALL clear to 0, and out_data to 0, at the next clk edge.
REQ-027 Reset mid-operation SHALL discard in-flight entries; in_ready SHALL be 0 during rst and 1 on the first cycle after rst falls.

Configuration
REQ-028 Macro SHIFT_PIPE_ROTATE_EN: when defined, ROL/ROR SHALL operate per REQ-015.
REQ-029 Without SHIFT_PIPE_ROTATE_EN, codes 100/101 SHALL be illegal per REQ-024, and no rotate logic is synthesized.

Structure
REQ-030 Shared package shift_pkg SHALL hold the op-code constants/enum shift_op_t, and a stage payload struct typedef.
REQ-031 One sub-module shift_stage SHALL implement a single registered stage, parametrised by WIDTH and stage index; shift_pipe instantiates SHW of them.

Verification (WIDTH=8, latency 3)
REQ-032 SLL, 0x81, amt 1 -> out_data 0x02, out_err 0, three cycles after acceptance.
REQ-033 SRA 0x80 amt 3 -> 0xF0; SRL 0x80 amt 3 -> 0x10; PASS 0x5A amt 7 -> 0x5A.
REQ-034 ROR 0x01 amt 1 -> 0x80 with the macro defined; without it -> 0x00, out_err 1; op 111 -> 0x00, out_err 1.
REQ-035 Back-to-back streaming of 4 ops with out_ready low for 2 cycles mid-stream -> in_ready low, outputs stable, all 4 results in order, none lost.
REQ-036 rst asserted with 2 entries in flight -> no out_valid afterwards; the next accepted op yields a correct result after 3 cycles.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared op codes, stage control payload and op legality for shift_pipe.
// Rotate ops are legal only when SHIFT_PIPE_ROTATE_EN is defined.
package shift_pkg;

  localparam int MAX_SHW = 6;

  typedef enum logic [2:0] {
    OP_PASS = 3'b000,
    OP_SLL  = 3'b001,
    OP_SRL  = 3'b010,
    OP_SRA  = 3'b011,
    OP_ROL  = 3'b100,
    OP_ROR  = 3'b101
  } shift_op_t;

  // Control half of a stage payload; data travels alongside at WIDTH bits.
  typedef struct packed {
    logic               vld;
    logic               err;
    shift_op_t          op;
    logic [MAX_SHW-1:0] amt;
  } stage_ctl_t;

  function automatic logic op_legal(input shift_op_t op);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_PASS, OP_SLL, OP_SRL, OP_SRA: ok = 1'b1;
`ifdef SHIFT_PIPE_ROTATE_EN
      OP_ROL, OP_ROR:                  ok = 1'b1;
`endif
      default:                         ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One registered barrel-shifter stage: applies a shift of 2^STAGE when amt[STAGE] is set.
// Rotate paths exist only under SHIFT_PIPE_ROTATE_EN; holds its contents when advance is low.
module shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STAGE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  input  stage_ctl_t       in_ctl,
  input  logic [WIDTH-1:0] in_data,
  output stage_ctl_t       out_ctl,
  output logic [WIDTH-1:0] out_data
);

  localparam int SH = 1 << STAGE;

  logic [WIDTH-1:0] nxt_data;

  always_comb begin
    nxt_data = in_data;
    if (in_ctl.err) begin
      nxt_data = '0;
    end else if (in_ctl.amt[STAGE]) begin
      case (in_ctl.op)
        OP_SLL:  nxt_data = in_data << SH;
        OP_SRL:  nxt_data = in_data >> SH;
        OP_SRA:  nxt_data = WIDTH'($signed(in_data) >>> SH);
`ifdef SHIFT_PIPE_ROTATE_EN
        OP_ROL:  nxt_data = (in_data << SH) | (in_data >> (WIDTH - SH));
        OP_ROR:  nxt_data = (in_data >> SH) | (in_data << (WIDTH - SH));
`endif
        default: nxt_data = in_data;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_ctl  <= '0;
      out_data <= '0;
    end else if (advance) begin
      out_ctl  <= in_ctl;
      out_data <= nxt_data;
    end
  end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined shifter/rotator, SHW stages, one result per cycle; illegal ops give 0 with out_err.
// Whole pipe stalls while the output is held; rotates need SHIFT_PIPE_ROTATE_EN.
module shift_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err
);

  stage_ctl_t       ctl  [SHW+1];
  logic [WIDTH-1:0] data [SHW+1];
  logic             advance;
  shift_op_t        op_in;

  assign advance  = !(out_valid && !out_ready);
  assign in_ready = advance && !rst;
  assign op_in    = shift_op_t'(in_op);

  // Legality is decided once on entry; later stages just carry err forward.
  assign ctl[0] = '{vld: in_valid, err: !op_legal(op_in), op: op_in,
                    amt: MAX_SHW'(in_amt)};
  assign data[0] = in_data;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    shift_stage #(.WIDTH(WIDTH), .STAGE(k)) u_stage (
      .clk     (clk),
      .rst     (rst),
      .advance (advance),
      .in_ctl  (ctl[k]),
      .in_data (data[k]),
      .out_ctl (ctl[k+1]),
      .out_data(data[k+1])
    );
  end

  assign out_valid = ctl[SHW].vld;
  assign out_err   = ctl[SHW].err;
  assign out_data  = data[SHW];

  logic unused_ctl;
  assign unused_ctl = ^{ctl[SHW].op, ctl[SHW].amt};

endmodule

// File: tb/tb_shift_pipe.sv
// Scoreboard bench for shift_pipe (WIDTH=8); expectations follow SHIFT_PIPE_ROTATE_EN if defined.
module tb_shift_pipe;

  localparam int WIDTH = 8;
  localparam int SHW   = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_amt;
  logic [2:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_err;

  shift_pipe #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_amt(in_amt), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             err;
    int               due;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   stall_cnt = 0;
  logic prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data;
  logic prev_err;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, wanted %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expected results, checks stall behaviour and hold stability.
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall) begin
        chk("hold_data", out_data, prev_data);
        chk("hold_err", out_err, prev_err);
      end
      if (out_valid && !out_ready) begin
        stall_cnt++;
        chk("stall_in_ready", in_ready, 0);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_out_valid", out_valid, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_err", out_err, e.err);
          if (e.due >= 0) chk("latency_cycle", cyc, e.due);
        end
      end
    end
    prev_stall = out_valid && !out_ready && !rst;
    prev_data  = out_data;
    prev_err   = out_err;
  end

  task automatic send(input logic [2:0] op, input logic [7:0] d, input logic [2:0] a,
                      input logic [7:0] ed, input logic ee, input bit lat);
    exp_t e;
    int   t;
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    in_amt   = a;
    t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("in_ready_timeout", in_ready, 1);
    e.data = ed;
    e.err  = ee;
    e.due  = lat ? cyc + SHW : -1;
    q.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("drain_queue_empty", q.size(), 0);
  endtask

  logic [7:0] ror_exp, rol_exp, ror2_exp;
  logic       rot_err;

  initial begin
`ifdef SHIFT_PIPE_ROTATE_EN
    ror_exp = 8'h80; rol_exp = 8'h0C; ror2_exp = 8'h69; rot_err = 1'b0;
`else
    ror_exp = 8'h00; rol_exp = 8'h00; ror2_exp = 8'h00; rot_err = 1'b1;
`endif
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_amt = '0; in_op = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    #1 chk("post_rst_in_ready", in_ready, 1);

    // Isolated op with latency check
    send(3'b001, 8'h81, 3'd1, 8'h02, 1'b0, 1'b1);
    drain();

    // Back-to-back stream of directed vectors
    send(3'b011, 8'h80, 3'd3, 8'hF0, 1'b0, 1'b1);
    send(3'b010, 8'h80, 3'd3, 8'h10, 1'b0, 1'b1);
    send(3'b000, 8'h5A, 3'd7, 8'h5A, 1'b0, 1'b1);
    send(3'b101, 8'h01, 3'd1, ror_exp, rot_err, 1'b1);
    send(3'b111, 8'hA5, 3'd2, 8'h00, 1'b1, 1'b1);
    send(3'b100, 8'h81, 3'd3, rol_exp, rot_err, 1'b1);
    send(3'b001, 8'hFF, 3'd0, 8'hFF, 1'b0, 1'b1);
    send(3'b011, 8'h7F, 3'd6, 8'h01, 1'b0, 1'b1);
    send(3'b010, 8'h96, 3'd5, 8'h04, 1'b0, 1'b1);
    send(3'b110, 8'hFF, 3'd1, 8'h00, 1'b1, 1'b1);
    send(3'b101, 8'h96, 3'd4, ror2_exp, rot_err, 1'b1);
    drain();

    // Streaming with a 2-cycle output stall in the middle
    stall_cnt = 0;
    fork
      begin
        send(3'b001, 8'h01, 3'd7, 8'h80, 1'b0, 1'b0);
        send(3'b010, 8'hF0, 3'd2, 8'h3C, 1'b0, 1'b0);
        send(3'b011, 8'h90, 3'd1, 8'hC8, 1'b0, 1'b0);
        send(3'b000, 8'h33, 3'd0, 8'h33, 1'b0, 1'b0);
      end
      begin
        int t;
        t = 0;
        while (!out_valid && t < 30) begin
          @(negedge clk);
          t++;
        end
        @(posedge clk);
        #2 out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2 out_ready = 1'b1;
      end
    join
    drain();
    chk("stall_cycles_seen", stall_cnt, 2);

    // Reset with two entries in flight
    send(3'b001, 8'h0F, 3'd1, 8'h1E, 1'b0, 1'b0);
    send(3'b010, 8'hF0, 3'd1, 8'h78, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    q.delete();
    #1 chk("mid_rst_in_ready", in_ready, 0);
    @(negedge clk);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_out_err", out_err, 0);
    rst = 1'b0;
    #1 chk("after_rst_in_ready", in_ready, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("flushed_out_valid", out_valid, 0);
    end
    send(3'b001, 8'h3C, 3'd2, 8'hF0, 1'b0, 1'b1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, wanted completion");
    $fatal(1, "watchdog");
  end

endmodule
